// File: rtl/wb_multi_counter.sv
// wb_multi_counter: bank of CHANNELS independent up/down counters behind a Wishbone slave.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i    Wishbone request; adr[7:4] = channel, adr[3:2] = register
//   wbs_dat_i, wbs_adr_i          write data, address
//   wbs_ack_o, wbs_dat_o          one-cycle acknowledge, read data (0 outside the ack cycle)
//   la_data_in, la_oenb           logic-analyzer inputs (used only with COUNTER_LA_CTRL_EN)
//   la_data_out                   channel 0 count with COUNTER_LA_CTRL_EN, else 0
//   count_o                       all counts concatenated, channel 0 in the LSBs
//   irq_o                         per-channel level interrupt, STATUS & IRQ_EN
//
// Register map per channel: 0 CTRL {STATUS, IRQ_EN, DIR, EN}, 1 STEP, 2 COUNT, 3 LIMIT.
// Optional feature macro: COUNTER_LA_CTRL_EN (LA freeze/clear per channel).
module wb_multi_counter #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_STEP = 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [31:0]               la_data_in,
  input  logic [31:0]               la_oenb,
  output logic [31:0]               la_data_out,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       irq_o
);

  logic       valid;
  logic [3:0] chan;
  logic [1:0] regsel;
  logic       ack_q;
  logic       bus_wr;
  logic [31:0] byte_mask;

  logic [WIDTH-1:0] count_q [CHANNELS];
  logic [WIDTH-1:0] count_d [CHANNELS];
  logic [WIDTH-1:0] step_q  [CHANNELS];
  logic [WIDTH-1:0] step_d  [CHANNELS];
  logic [WIDTH-1:0] limit_q [CHANNELS];
  logic [WIDTH-1:0] limit_d [CHANNELS];
  logic [WIDTH:0]   sum     [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d, dir_q, dir_d, irqen_q, irqen_d, status_q, status_d;
  logic [CHANNELS-1:0] sel_ch, run, hit, la_freeze, la_clear;

  assign valid     = wbs_cyc_i & wbs_stb_i;
  assign chan      = wbs_adr_i[7:4];
  assign regsel    = wbs_adr_i[3:2];
  // Writes commit on the edge that closes the ack cycle.
  assign bus_wr    = ack_q & valid & wbs_we_i;
  assign wbs_ack_o = ack_q;

  logic unused;
  assign unused = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], la_data_in, la_oenb};

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old,
                                                   input logic [31:0] data,
                                                   input logic [31:0] mask);
    logic [31:0] full;
    full = (32'(old) & ~mask) | (data & mask);
    return full[WIDTH-1:0];
  endfunction

`ifdef COUNTER_LA_CTRL_EN
  always_comb begin
    la_freeze = '0;
    la_clear  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      la_freeze[i] = ~la_oenb[i] & la_data_in[i];
      la_clear[i]  = ~la_oenb[16+i] & la_data_in[16+i];
    end
    la_data_out = 32'(count_q[0]);
  end
`else
  assign la_freeze   = '0;
  assign la_clear    = '0;
  assign la_data_out = '0;
`endif

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{wbs_sel_i[b]}};
  end

  always_comb begin
    sel_ch    = '0;
    run       = '0;
    hit       = '0;
    en_d      = en_q;
    dir_d     = dir_q;
    irqen_d   = irqen_q;
    status_d  = status_q;
    wbs_dat_o = '0;
    count_o   = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      count_d[i] = count_q[i];
      step_d[i]  = step_q[i];
      limit_d[i] = limit_q[i];
      // Out-of-range channel numbers never match any i, so they read 0 and write nothing.
      sel_ch[i]  = (chan == 4'(i));
      sum[i]     = {1'b0, count_q[i]} + {1'b0, step_q[i]};
      run[i]     = en_q[i] & ~la_freeze[i] & (step_q[i] != '0);

      if (run[i]) begin
        if (dir_q[i]) begin
          hit[i]     = count_q[i] < step_q[i];
          count_d[i] = hit[i] ? limit_q[i] : count_q[i] - step_q[i];
        end else begin
          hit[i]     = sum[i] > {1'b0, limit_q[i]};
          count_d[i] = hit[i] ? '0 : sum[i][WIDTH-1:0];
        end
      end

      if (bus_wr && sel_ch[i]) begin
        case (regsel)
          2'd0: begin
            if (wbs_sel_i[0]) begin
              en_d[i]    = wbs_dat_i[0];
              dir_d[i]   = wbs_dat_i[1];
              irqen_d[i] = wbs_dat_i[2];
              if (wbs_dat_i[3]) status_d[i] = 1'b0;
            end
          end
          2'd1: step_d[i]  = merge_bytes(step_q[i], wbs_dat_i, byte_mask);
          2'd2: count_d[i] = merge_bytes(count_q[i], wbs_dat_i, byte_mask);
          default: limit_d[i] = merge_bytes(limit_q[i], wbs_dat_i, byte_mask);
        endcase
      end

      if (la_clear[i]) count_d[i] = '0;
      // A hit outranks a simultaneous write-1-to-clear.
      if (hit[i]) status_d[i] = 1'b1;

      if (ack_q && sel_ch[i]) begin
        case (regsel)
          2'd0:    wbs_dat_o = {28'd0, status_q[i], irqen_q[i], dir_q[i], en_q[i]};
          2'd1:    wbs_dat_o = 32'(step_q[i]);
          2'd2:    wbs_dat_o = 32'(count_q[i]);
          default: wbs_dat_o = 32'(limit_q[i]);
        endcase
      end

      count_o[i*WIDTH +: WIDTH] = count_q[i];
    end
  end

  assign irq_o = status_q & irqen_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      en_q     <= '0;
      dir_q    <= '0;
      irqen_q  <= '0;
      status_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        count_q[i] <= '0;
        step_q[i]  <= WIDTH'(DEFAULT_STEP);
        limit_q[i] <= '1;
      end
    end else begin
      ack_q    <= valid & ~ack_q;
      en_q     <= en_d;
      dir_q    <= dir_d;
      irqen_q  <= irqen_d;
      status_q <= status_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        count_q[i] <= count_d[i];
        step_q[i]  <= step_d[i];
        limit_q[i] <= limit_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_multi_counter.sv
// Directed self-checking bench for wb_multi_counter (default parameters: 4 channels, 16 bits).
module tb_wb_multi_counter;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   dat_i = '0, adr = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic [31:0]   la_in = '0, la_oenb = '1, la_out;
  logic [CH*W-1:0] count;
  logic [CH-1:0] irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;

  wb_multi_counter dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (dat_i),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .la_data_in  (la_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_out),
    .count_o     (count),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'((ch << 4) | (r << 2));
  endfunction

  function automatic logic [31:0] cnt(input int ch);
    return 32'(count[ch*W +: W]);
  endfunction

  // Called just after a rising edge; returns just after the edge that closes the ack cycle.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    #1 check_eq("ack_before", 32'(ack), 32'd0);
    @(posedge clk); #1;
    check_eq("ack_cycle", 32'(ack), 32'd1);
    r = dat_o;
    @(posedge clk); #1;
    check_eq("ack_one_cycle", 32'(ack), 32'd0);
    check_eq("dat_idle", dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    bus_xfer(1'b0, a, 32'd0, 4'hF, r);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rst_cnt_lo", count[31:0], 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_la", la_out, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // ch0 reset register values
    wb_read(ra(0, 0), rd); check_eq("ch0_ctrl", rd, 32'h0);
    wb_read(ra(0, 1), rd); check_eq("ch0_step", rd, 32'h1);
    wb_read(ra(0, 2), rd); check_eq("ch0_count", rd, 32'h0);
    wb_read(ra(0, 3), rd); check_eq("ch0_limit", rd, 32'hFFFF);

    // Out-of-range channel and byte strobes
    wb_write(ra(5, 3), 32'h1234, 4'hF);
    wb_write(ra(5, 0), 32'h7, 4'hF);
    wb_read(ra(5, 3), rd); check_eq("ch5_read", rd, 32'h0);
    check_eq("ch5_no_cnt_lo", count[31:0], 32'h0);
    check_eq("ch5_no_cnt_hi", count[63:32], 32'h0);
    wb_read(ra(1, 3), rd); check_eq("ch1_limit_untouched", rd, 32'hFFFF);
    wb_read(ra(1, 0), rd); check_eq("ch1_ctrl_untouched", rd, 32'h0);
    wb_write(ra(0, 3), 32'hDEAD_AB12, 4'b0001);
    wb_read(ra(0, 3), rd); check_eq("ch0_limit_byte0", rd, 32'hFF12);

    // ch1 up-count with wrap: 0,3,6,9,0
    wb_write(ra(1, 3), 32'd10, 4'hF);
    wb_write(ra(1, 1), 32'd3, 4'hF);
    wb_write(ra(1, 0), 32'h5, 4'hF);
    check_eq("ch1_c0", cnt(1), 32'd0);
    begin
      logic [31:0] exp_c [4];
      exp_c = '{32'd3, 32'd6, 32'd9, 32'd0};
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        check_eq($sformatf("ch1_c%0d", k + 1), cnt(1), exp_c[k]);
        check_eq($sformatf("ch1_irq%0d", k + 1), 32'(irq[1]), (k == 3) ? 32'd1 : 32'd0);
      end
    end

    // Clear STATUS on the same edge as the next hit: STATUS stays set
    repeat (2) @(posedge clk);
    #1 wb_write(ra(1, 0), 32'hD, 4'hF);
    wb_read(ra(1, 0), rd); check_eq("ch1_ctrl_clr_vs_hit", rd, 32'hD);
    check_eq("ch1_irq_held", 32'(irq[1]), 32'd1);
    // Clear without a coincident hit, stop counting, keep IRQ_EN
    @(posedge clk); #1;
    wb_write(ra(1, 0), 32'hC, 4'hF);
    check_eq("ch1_irq_cleared", 32'(irq[1]), 32'd0);
    check_eq("ch1_frozen", cnt(1), 32'd3);
    wb_read(ra(1, 0), rd); check_eq("ch1_ctrl_cleared", rd, 32'h4);

    // ch2 down-count: 3 -> 1, 7 (hit), 5, 3
    wb_write(ra(2, 3), 32'd7, 4'hF);
    wb_write(ra(2, 1), 32'd2, 4'hF);
    wb_write(ra(2, 2), 32'd3, 4'hF);
    wb_write(ra(2, 0), 32'h3, 4'hF);
    check_eq("ch2_c0", cnt(2), 32'd3);
    begin
      logic [31:0] exp_d [4];
      exp_d = '{32'd1, 32'd7, 32'd5, 32'd3};
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        check_eq($sformatf("ch2_c%0d", k + 1), cnt(2), exp_d[k]);
      end
    end
    // Disabling takes effect after two more counting edges: 3 -> 1 -> 7
    wb_write(ra(2, 0), 32'h0, 4'hF);
    check_eq("ch2_stopped", cnt(2), 32'd7);
    wb_read(ra(2, 0), rd); check_eq("ch2_status", rd, 32'h8);
    wb_write(ra(2, 0), 32'h4, 4'hF);
    check_eq("irq_vector", 32'(irq), 32'h4);

    // LA path on ch0 (counting up by 1, limit 0xFF12)
    wb_write(ra(0, 0), 32'h1, 4'hF);
    check_eq("ch0_start", cnt(0), 32'd0);
    @(posedge clk); #1;
    check_eq("ch0_c1", cnt(0), 32'd1);
    la_oenb = 32'hFFFF_FFFE; la_in = 32'h0000_0001;
    @(posedge clk); #1;
`ifdef COUNTER_LA_CTRL_EN
    check_eq("la_freeze", cnt(0), 32'd1);
    check_eq("la_out", la_out, 32'd1);
`else
    check_eq("la_ignored", cnt(0), 32'd2);
    check_eq("la_out_zero", la_out, 32'd0);
`endif
    la_oenb = 32'hFFFE_FFFF; la_in = 32'h0001_0000;
    @(posedge clk); #1;
`ifdef COUNTER_LA_CTRL_EN
    check_eq("la_clear", cnt(0), 32'd0);
`else
    check_eq("la_clear_ignored", cnt(0), 32'd3);
`endif
    la_oenb = '1; la_in = '0;

    // Reset in the middle of a write transaction
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = ra(0, 2); dat_i = 32'h55; sel = 4'hF;
    @(posedge clk); #1;
    check_eq("mid_ack", 32'(ack), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_ack", 32'(ack), 32'd0);
    check_eq("arst_dat", dat_o, 32'd0);
    check_eq("arst_cnt_lo", count[31:0], 32'd0);
    check_eq("arst_cnt_hi", count[63:32], 32'd0);
    check_eq("arst_irq", 32'(irq), 32'd0);
    check_eq("arst_la", la_out, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("no_late_ack", 32'(ack), 32'd0);
      check_eq("cnt_after_rst", count[31:0], 32'd0);
    end
    wb_read(ra(1, 3), rd); check_eq("ch1_limit_reset", rd, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
